// File: rtl/oam_dma.sv
// OAM DMA engine: copies XFER_LEN bytes from a 256-byte source page to DST_BASE, one byte per slot.
// Optional echo-RAM page remap at capture is enabled by defining OAM_DMA_ECHO_REMAP_EN.
module oam_dma #(
    parameter int unsigned XFER_LEN        = 160,
    parameter logic [15:0] DST_BASE        = 16'hFE00,
    parameter int unsigned CYCLES_PER_BYTE = 4,
    parameter int unsigned START_DELAY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  src_page,
    input  logic        bus_gnt,
    input  logic [7:0]  r_data,
    output logic        bus_req,
    output logic [15:0] r_addr,
    output logic [15:0] w_addr,
    output logic [7:0]  w_data,
    output logic        wen,
    output logic        busy,
    output logic        done
);

    localparam int unsigned TW       = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam logic [TW-1:0] LAST_T = TW'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0] LAST_IDX  = 8'(XFER_LEN - 1);
    localparam logic [15:0] DLY_LOAD = 16'(START_DELAY * CYCLES_PER_BYTE - 1);

    typedef enum logic [2:0] {StIdle, StReq, StDelay, StXfer, StDone} state_e;

    state_e        state_q, state_d;
    logic [7:0]    page_q, page_d;
    logic [7:0]    idx_q, idx_d;
    logic [TW-1:0] t_q, t_d;
    logic [15:0]   dly_q, dly_d;

    function automatic logic [7:0] capture_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_REMAP_EN
        // E0..FF alias C0..DF on the DMG bus decode.
        return (p >= 8'hE0) ? (p - 8'h20) : p;
`else
        return p;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            t_q     <= '0;
            dly_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            t_q     <= t_d;
            dly_q   <= dly_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        t_d     = t_q;
        dly_d   = dly_q;
        bus_req = 1'b0;
        busy    = (state_q != StIdle);
        done    = 1'b0;
        wen     = 1'b0;
        r_addr  = 16'h0000;
        w_addr  = 16'h0000;
        w_data  = r_data;

        unique case (state_q)
            StIdle: begin
            end
            StReq: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    if (START_DELAY == 0) begin
                        state_d = StXfer;
                        t_d     = '0;
                    end else begin
                        state_d = StDelay;
                        dly_d   = DLY_LOAD;
                    end
                end
            end
            StDelay: begin
                bus_req = 1'b1;
                r_addr  = {page_q, idx_q};
                w_addr  = DST_BASE + {8'h00, idx_q};
                if (bus_gnt) begin
                    if (dly_q == 16'h0000) begin
                        state_d = StXfer;
                        t_d     = '0;
                    end else begin
                        dly_d = dly_q - 16'h0001;
                    end
                end
            end
            StXfer: begin
                bus_req = 1'b1;
                r_addr  = {page_q, idx_q};
                w_addr  = DST_BASE + {8'h00, idx_q};
                wen     = bus_gnt && (t_q == LAST_T);
                // Without the grant every counter holds, so the slot resumes where it stopped.
                if (bus_gnt) begin
                    if (t_q == LAST_T) begin
                        t_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = StDone;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A start in any state restarts; it overrides the DONE transition of a finishing copy.
        if (start) begin
            page_d  = capture_page(src_page);
            idx_d   = 8'h00;
            state_d = StReq;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: per-cycle compare against a progress-count model of the copy,
// plus directed timing/content checks and randomized grant/restart traffic.
module tb_oam_dma;

    localparam int          XL  = 160;
    localparam int          CPB = 4;
    localparam int          SD  = 1;
    localparam int          D   = SD * CPB;
    localparam logic [15:0] DST = 16'hFE00;
`ifdef OAM_DMA_ECHO_REMAP_EN
    localparam logic [15:0] ECHO_FIRST = 16'hC100;
`else
    localparam logic [15:0] ECHO_FIRST = 16'hE100;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  src_page = 8'h00;
    logic        bus_gnt = 1'b0;
    logic [7:0]  r_data;
    logic        bus_req;
    logic [15:0] r_addr;
    logic [15:0] w_addr;
    logic [7:0]  w_data;
    logic        wen;
    logic        busy;
    logic        done;

    logic [7:0] mem    [0:65535];
    logic [7:0] shadow [0:65535];

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1 waiting for grant, 2 granted (m_k granted clocks so far), 3 done.
    int         m_phase = 0;
    int         m_k     = 0;
    logic [7:0] m_page  = 8'h00;

    int          e_cnt       = 0;
    int          first_wen_e = -1;
    int          done_e      = -1;
    int          wen_cnt     = 0;
    int          done_cnt    = 0;
    logic [15:0] first_wen_raddr = 16'h0000;

    assign r_data = mem[r_addr];

    oam_dma dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_page (src_page),
        .bus_gnt  (bus_gnt),
        .r_data   (r_data),
        .bus_req  (bus_req),
        .r_addr   (r_addr),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .wen      (wen),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] remap(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_REMAP_EN
        return (p >= 8'hE0) ? (p - 8'h20) : p;
`else
        return p;
`endif
    endfunction

    // Runs at each negedge: compare outputs, commit a write, then advance the model.
    task automatic cycle_check();
        logic        x_req, x_busy, x_done, x_wen;
        logic [15:0] x_ra, x_wa;
        int          idx;
        if (!rst_n) begin
            m_phase = 0;
            m_k     = 0;
            check("rst_bus_req", bus_req, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_wen", wen, 0);
            check("rst_r_addr", r_addr, 0);
        end else begin
            idx    = 0;
            x_wen  = 1'b0;
            x_ra   = 16'h0000;
            x_wa   = 16'h0000;
            x_busy = (m_phase != 0);
            x_req  = (m_phase == 1) || (m_phase == 2);
            x_done = (m_phase == 3);
            if (m_phase == 2) begin
                if (m_k >= D) idx = (m_k - D) / CPB;
                x_ra  = {m_page, 8'(idx)};
                x_wa  = DST + 16'(idx);
                x_wen = bus_gnt && (m_k >= D) && (((m_k - D) % CPB) == CPB - 1);
            end
            check("bus_req", bus_req, x_req);
            check("busy", busy, x_busy);
            check("done", done, x_done);
            check("wen", wen, x_wen);
            check("r_addr", r_addr, x_ra);
            check("w_addr", w_addr, x_wa);
            check("w_data", w_data, mem[r_addr]);

            if (wen) begin
                wen_cnt++;
                if (first_wen_e < 0) begin
                    first_wen_e     = e_cnt;
                    first_wen_raddr = r_addr;
                end
                mem[w_addr] = w_data;
            end
            if (done) begin
                done_cnt++;
                done_e = e_cnt;
            end

            if (start) begin
                m_phase     = 1;
                m_page      = remap(src_page);
                m_k         = 0;
                first_wen_e = -1;
                e_cnt       = 1;
            end else begin
                e_cnt++;
                case (m_phase)
                    1: if (bus_gnt) begin
                        m_phase = 2;
                        m_k     = 0;
                    end
                    2: if (bus_gnt) begin
                        if (x_wen && idx == XL - 1) m_phase = 3;
                        else m_k++;
                    end
                    3: m_phase = 0;
                    default: m_phase = 0;
                endcase
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic preload(input logic [7:0] p);
        logic [7:0] d;
        for (int i = 0; i < XL; i++) begin
            d = 8'($urandom);
            mem[{p, 8'(i)}]    = d;
            shadow[{p, 8'(i)}] = d;
        end
    endtask

    task automatic clear_oam(input logic [7:0] p);
        for (int i = 0; i < XL; i++) mem[DST + 16'(i)] = ~shadow[{p, 8'(i)}];
    endtask

    task automatic check_oam(input logic [7:0] p);
        for (int i = 0; i < XL; i++) check("oam_byte", mem[DST + 16'(i)], shadow[{p, 8'(i)}]);
    endtask

    task automatic pulse_start(input logic [7:0] p);
        start    = 1'b1;
        src_page = p;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) step();
        check("done_seen", done_cnt - d0, 1);
    endtask

    initial begin
        int w0, w1, d0;
        logic [7:0] pg, pg2, cur;

        #2;
        check("reset_bus_req", bus_req, 0);
        check("reset_busy", busy, 0);
        check("reset_r_addr", r_addr, 0);
        check("reset_w_addr", w_addr, 0);
        step();
        rst_n = 1'b1;
        steps(2);

        // Ramp transfer with grant tied high.
        for (int i = 0; i < XL; i++) begin
            mem[16'hC000 + 16'(i)]    = 8'(i);
            shadow[16'hC000 + 16'(i)] = 8'(i);
        end
        clear_oam(8'hC0);
        bus_gnt = 1'b1;
        w0 = wen_cnt;
        pulse_start(8'hC0);
        wait_done(800);
        check("t1_first_wen_edge", first_wen_e, 9);
        check("t1_done_edge", done_e, 646);
        check("t1_wen_total", wen_cnt - w0, 160);
        check("t1_oam_first", mem[16'hFE00], 8'h00);
        check("t1_oam_last", mem[16'hFE9F], 8'h9F);
        check_oam(8'hC0);
        steps(3);

        // Grant lost for 20 cycles in the middle of byte 50's slot.
        clear_oam(8'hC0);
        w0 = wen_cnt;
        pulse_start(8'hC0);
        steps(207);
        bus_gnt = 1'b0;
        w1 = wen_cnt;
        steps(20);
        check("t2_wen_during_loss", wen_cnt - w1, 0);
        bus_gnt = 1'b1;
        wait_done(800);
        check("t2_done_edge", done_e, 666);
        check("t2_wen_total", wen_cnt - w0, 160);
        check_oam(8'hC0);
        steps(3);

        // Restart with page D0 at idx 30.
        preload(8'hD0);
        clear_oam(8'hD0);
        d0 = done_cnt;
        pulse_start(8'hC0);
        steps(129);
        pulse_start(8'hD0);
        wait_done(800);
        steps(5);
        check("t3_done_count", done_cnt - d0, 1);
        check("t3_done_edge", done_e, 646);
        check_oam(8'hD0);

        // Asynchronous reset mid-transfer at idx 70.
        pulse_start(8'hC0);
        steps(287);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_bus_req", bus_req, 0);
        check("t4_async_busy", busy, 0);
        check("t4_async_wen", wen, 0);
        check("t4_async_done", done, 0);
        steps(2);
        rst_n = 1'b1;
        w0 = wen_cnt;
        steps(50);
        check("t4_no_writes_after_reset", wen_cnt - w0, 0);
        check("t4_idle_busy", busy, 0);

        // Echo page E1.
        preload(8'hE1);
        preload(remap(8'hE1));
        clear_oam(remap(8'hE1));
        pulse_start(8'hE1);
        wait_done(800);
        check("t5_first_r_addr", first_wen_raddr, ECHO_FIRST);
        check_oam(remap(8'hE1));
        steps(3);

        // Grant withheld for 50 cycles after start.
        bus_gnt = 1'b0;
        w0 = wen_cnt;
        pulse_start(8'hC0);
        steps(50);
        check("t6_wen_no_grant", wen_cnt - w0, 0);
        check("t6_bus_req_held", bus_req, 1);
        check("t6_busy_held", busy, 1);
        bus_gnt = 1'b1;
        wait_done(800);
        check("t6_first_wen_edge", first_wen_e, 59);
        steps(3);

        // Random pages, random grant, occasional restart.
        for (int n = 0; n < 4; n++) begin
            do pg = 8'($urandom); while (remap(pg) == 8'hFE);
            do pg2 = 8'($urandom); while (remap(pg2) == 8'hFE || remap(pg2) == remap(pg));
            preload(remap(pg));
            preload(remap(pg2));
            clear_oam(remap(pg));
            cur = pg;
            d0 = done_cnt;
            bus_gnt = ($urandom_range(0, 3) != 0);
            pulse_start(pg);
            for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
                bus_gnt = ($urandom_range(0, 3) != 0);
                if (cur == pg && $urandom_range(0, 299) == 0) begin
                    cur = pg2;
                    pulse_start(pg2);
                end else begin
                    step();
                end
            end
            check("rnd_done_count", done_cnt - d0, 1);
            check_oam(remap(cur));
            bus_gnt = 1'b1;
            steps(3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Bus initiator that copies a 256-byte-aligned source page into OAM.
- Drives the same single-port-style memory interface the CPU core uses (r_addr/r_data read, w_addr/w_data/wen write) and sits beside the sm83 core behind a bus request/grant arbiter.
- Models the DMG FF46 OAM DMA engine: triggered by a start pulse carrying the source page, it moves XFER_LEN bytes at one byte per M-cycle, then reports done.

Parameters:
- XFER_LEN, 160, number of bytes copied per transfer (index range 0..XFER_LEN-1).
- DST_BASE, 16'hFE00, destination base address.
- CYCLES_PER_BYTE, 4, clocks per byte slot (one M-cycle).
- START_DELAY, 1, M-cycles of setup delay after grant before the first byte slot.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle trigger (models the write to FF46).
- src_page  in  8  source high byte, sampled when start=1.
- bus_gnt  in  1  arbiter grant; the block owns the memory bus only while this is high.
- r_data  in  8  read data, combinational from r_addr.
- bus_req  out  1  bus request.
- r_addr  out  16  read address = {page_q, idx}.
- w_addr  out  16  write address = DST_BASE + idx.
- w_data  out  8  write data = r_data (combinational pass-through).
- wen  out  1  write enable, committed by memory at the next posedge.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, idx=0, page_q=0, slot counter t=0, delay counter=0.
  - All outputs 0: bus_req, busy, done, wen, r_addr, w_addr. w_data follows r_data.
- States: IDLE, REQ, DELAY, XFER, DONE.
- IDLE:
  - start=1 at an edge captures page_q=src_page, idx=0, and moves to REQ.
- REQ:
  - bus_req=1.
  - bus_gnt=1 at an edge moves to DELAY and loads delay counter = START_DELAY*CYCLES_PER_BYTE-1.
- DELAY:
  - Counts down while bus_gnt=1; moves to XFER with t=0 when the count reaches 0.
  - START_DELAY=0 goes straight from REQ to XFER.
- XFER:
  - t increments modulo CYCLES_PER_BYTE while bus_gnt=1.
  - wen = (state==XFER) && (t==CYCLES_PER_BYTE-1) && bus_gnt (combinational).
  - On the wen edge, idx increments. After the write of idx=XFER_LEN-1, go to DONE.
- DONE:
  - done=1 and bus_req=0 for exactly one cycle, then IDLE.
  - busy=1 in DONE and 0 once in IDLE.
- bus_req=1 in REQ, DELAY and XFER.
- r_addr/w_addr are valid during DELAY and XFER; they are 0 in IDLE.
- Grant loss: bus_gnt=0 in DELAY or XFER freezes all counters, forces wen=0, and holds bus_req=1. Counting resumes on the same values when the grant returns. No byte is lost or duplicated.
- Restart: start=1 while busy recaptures src_page, resets idx=0, and goes to REQ. A wen already asserted in that same cycle still commits (old page), and no done pulse is issued for the aborted transfer.
- start in DONE is treated as a restart.
- Timing with bus_gnt tied high, start sampled at edge E0 (defaults):
  - REQ after E0, DELAY after E1, XFER after E5.
  - Byte i commits at edge E(9+4i); the last byte commits at E645.
  - done is high during the cycle after E645.
- Arithmetic: idx is 8 bits. w_addr = DST_BASE + idx, 16-bit, wrap ignored. XFER_LEN must be ≤256.

Optional Feature:
- Macro: OAM_DMA_ECHO_REMAP_EN.
- Defined: page_q values 8'hE0..8'hFF are reduced by 8'h20 at capture (E0→C0, FE→DE), matching DMG echo-RAM decode.
- Undefined: page_q = src_page unmodified.

Test Plan:
- Preload page C0 with 0x00..0x9F; pulse start with src_page=8'hC0, bus_gnt=1 → bytes FE00..FE9F = 0x00..0x9F; first wen in the cycle before E9; done pulses once, during the cycle after E645; 160 wen pulses total.
- Same transfer with bus_gnt low for 20 cycles starting mid-slot at idx=50 → wen stays 0 throughout; the final OAM contents are identical; done is delayed by exactly 20 cycles.
- start with src_page=8'hC0, then start with src_page=8'hD0 at idx=30 → FE00..FE9F hold page D0 data; exactly one done pulse.
- Assert rst_n=0 asynchronously at idx=70 → bus_req, busy, wen and done are 0 immediately; after release, no writes occur until the next start.
- With OAM_DMA_ECHO_REMAP_EN, src_page=8'hE1 → r_addr reads C100..C19F. Without the macro → r_addr reads E100..E19F.
- bus_gnt held 0 for 50 cycles after start → bus_req=1, busy=1, wen=0 throughout; the first wen comes 8 cycles after grant rises.
